// File: rtl/fifo_rd_packer.sv
// Drains a single-clock FIFO and packs PACK consecutive entries, little-endian,
// into one wide word on a valid/ready port. A flush pulse emits a partial word with lane enables.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_ready,
  input  logic                       fifo_rd_valid,
  input  logic [DATA_WIDTH-1:0]      fifo_rd_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [PACK-1:0]            out_be,
  output logic                       out_last,
  output logic                       err
);
  localparam int OW = DATA_WIDTH * PACK;

  logic [CNT_WIDTH-1:0] cnt;
  logic                 inflight;
  logic                 flush_pending;
  logic [OW-1:0]        asm_data;

  logic [CNT_WIDTH:0]   fill;
  logic                 rd_acc, capture, slot_free, full;
  logic                 do_full, do_part, flush_clear;
  logic [PACK-1:0]      part_be;
  logic [OW-1:0]        part_data;

  // Fill includes the outstanding read so the assembly register can never overflow.
  assign fill          = {1'b0, cnt} + (CNT_WIDTH+1)'(inflight);
  assign fifo_rd_ready = !rst && !flush_pending && (fill < (CNT_WIDTH+1)'(PACK));
  assign rd_acc        = fifo_rd_ready && !fifo_empty;
  assign capture       = fifo_rd_valid && inflight;
  assign slot_free     = !out_valid || out_ready;
  assign full          = (cnt == CNT_WIDTH'(PACK));
  assign do_full       = full && slot_free;
  assign flush_clear   = do_full || (flush_pending && !inflight && slot_free);
  assign do_part       = flush_pending && !inflight && slot_free && !full && (cnt != '0);

  // Partial word: only lanes below cnt are real; stale lanes are zeroed.
  always_comb begin
    part_be   = '0;
    part_data = '0;
    for (int i = 0; i < PACK; i++) begin
      if (CNT_WIDTH'(i) < cnt) begin
        part_be[i]                              = 1'b1;
        part_data[i*DATA_WIDTH +: DATA_WIDTH]   = asm_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      inflight      <= 1'b0;
      flush_pending <= 1'b0;
      asm_data      <= '0;
      err           <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_be        <= '0;
      out_last      <= 1'b0;
    end else begin
      inflight      <= rd_acc;
      flush_pending <= (flush_pending && !flush_clear) || flush;
      if (fifo_rd_valid && !inflight) err <= 1'b1;

      if (capture) begin
        for (int i = 0; i < PACK; i++)
          if (cnt == CNT_WIDTH'(i)) asm_data[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_rd_data;
        cnt <= cnt + 1'b1;
      end else if (do_full || do_part) begin
        cnt <= '0;
      end

      if (do_full) begin
        out_valid <= 1'b1;
        out_data  <= asm_data;
        out_be    <= '1;
        out_last  <= flush_pending;
      end else if (do_part) begin
        out_valid <= 1'b1;
        out_data  <= part_data;
        out_be    <= part_be;
        out_last  <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: behavioural FIFO in front, word scoreboard behind,
// directed scenarios plus randomized streams checked against a chunking model.
module tb_fifo_rd_packer;
  localparam int DW = 8;
  localparam int PK = 4;

  typedef struct packed {
    logic [DW*PK-1:0] d;
    logic [PK-1:0]    be;
    logic             last;
  } word_t;

  logic clk = 0, rst = 1;
  logic fifo_empty = 1, fifo_rd_ready, fifo_rd_valid = 0;
  logic [DW-1:0] fifo_rd_data = '0;
  logic flush = 0, out_valid, out_ready = 0;
  logic [DW*PK-1:0] out_data;
  logic [PK-1:0] out_be;
  logic out_last, err;

  logic [DW-1:0] fq[$];
  word_t got[$];
  logic inj = 0;
  logic [DW-1:0] inj_data = '0;
  int checks = 0, passes = 0;

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_ready(fifo_rd_ready),
    .fifo_rd_valid(fifo_rd_valid), .fifo_rd_data(fifo_rd_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_be(out_be),
    .out_last(out_last), .err(err)
  );

  always #5 clk = ~clk;

  // One clock: FIFO model answers accepted reads with 1-cycle latency, popped words are logged.
  task automatic tick();
    logic acc;
    acc = fifo_rd_ready && !fifo_empty;
    if (out_valid && out_ready) got.push_back('{out_data, out_be, out_last});
    @(posedge clk); #1;
    if (acc) begin
      fifo_rd_valid = 1'b1;
      fifo_rd_data  = fq.pop_front();
    end else begin
      fifo_rd_valid = inj;
      fifo_rd_data  = inj ? inj_data : '0;
    end
    inj = 0;
    flush = 0;
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic push(input logic [DW-1:0] d);
    fq.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", out_valid); else passes++;
    checks++; if (out_data !== '0) $display("FAIL reset_out_data: got %h exp 0", out_data); else passes++;
    checks++; if ({out_be, out_last, err} !== '0) $display("FAIL reset_be_last_err: got %b exp 0", {out_be, out_last, err}); else passes++;
    checks++; if (fifo_rd_ready !== 1'b0) $display("FAIL reset_rd_ready: got %b exp 0", fifo_rd_ready); else passes++;
    rst = 0;
    tick();
    checks++; if (fifo_rd_ready !== 1'b1) $display("FAIL idle_rd_ready: got %b exp 1", fifo_rd_ready); else passes++;
  endtask

  task automatic test_basic();
    logic e;
    got.delete();
    out_ready = 1;
    for (int i = 1; i <= 4; i++) push(DW'(i));
    for (int c = 0; c <= 6; c++) begin
      if (c <= 5) begin
        e = (c < 4);
        checks++; if (fifo_rd_ready !== e) $display("FAIL basic_rd_ready_c%0d: got %b exp %b", c, fifo_rd_ready, e); else passes++;
      end else begin
        checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid_c6: got %b exp 1", out_valid); else passes++;
      end
      tick();
    end
    checks++; if (got.size() != 1 || got[0] !== word_t'{32'h04030201, 4'hF, 1'b0})
      $display("FAIL basic_word: got %0d words first %h exp %h", got.size(), got.size() ? got[0] : '0, word_t'{32'h04030201, 4'hF, 1'b0});
    else passes++;
  endtask

  task automatic test_backpressure();
    got.delete();
    out_ready = 0;
    for (int i = 0; i < 8; i++) push(DW'(8'h10 + i));
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid) begin
        checks++; if (out_data !== 32'h13121110) $display("FAIL bp_hold_c%0d: got %h exp 13121110", c, out_data); else passes++;
      end
    end
    checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid: got %b exp 1", out_valid); else passes++;
    checks++; if (fifo_rd_ready !== 1'b0) $display("FAIL bp_stall: got %b exp 0", fifo_rd_ready); else passes++;
    out_ready = 1;
    for (int c = 0; c < 30 && got.size() < 2; c++) tick();
    checks++; if (got.size() != 2) $display("FAIL bp_count: got %0d exp 2", got.size());
    else if (got[0] !== word_t'{32'h13121110, 4'hF, 1'b0} || got[1] !== word_t'{32'h17161514, 4'hF, 1'b0})
      $display("FAIL bp_words: got %h %h exp 13121110 17161514", got[0].d, got[1].d);
    else passes++;
  endtask

  task automatic test_flush_partial();
    got.delete();
    out_ready = 1;
    push(8'hAA); push(8'hBB); push(8'hCC);
    for (int c = 0; c < 8; c++) tick();
    checks++; if (got.size() != 0) $display("FAIL fp_early: got %0d words exp 0", got.size()); else passes++;
    flush = 1;
    for (int c = 0; c < 10 && got.size() < 1; c++) tick();
    checks++; if (got.size() != 1 || got[0] !== word_t'{32'h00CCBBAA, 4'h7, 1'b1})
      $display("FAIL fp_word: got %0d words first %h exp %h", got.size(), got.size() ? got[0] : '0, word_t'{32'h00CCBBAA, 4'h7, 1'b1});
    else passes++;
    tick();
    checks++; if (fifo_rd_ready !== 1'b1) $display("FAIL fp_cnt_clear: got rd_ready %b exp 1", fifo_rd_ready); else passes++;
  endtask

  task automatic test_flush_inflight();
    got.delete();
    out_ready = 1;
    push(8'h55);
    flush = 1;
    tick();
    checks++; if (fifo_rd_ready !== 1'b0) $display("FAIL fi_no_read: got %b exp 0", fifo_rd_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL fi_n1_valid: got %b exp 0", out_valid); else passes++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL fi_n2_valid: got %b exp 0", out_valid); else passes++;
    for (int c = 0; c < 10 && got.size() < 1; c++) tick();
    checks++; if (got.size() != 1 || got[0] !== word_t'{32'h00000055, 4'h1, 1'b1})
      $display("FAIL fi_word: got %0d words first %h exp %h", got.size(), got.size() ? got[0] : '0, word_t'{32'h55, 4'h1, 1'b1});
    else passes++;
    flush = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL fi_empty_flush_c%0d: got %b exp 0", c, out_valid); else passes++;
    end
  endtask

  task automatic test_err();
    got.delete();
    out_ready = 1;
    inj = 1; inj_data = 8'hEE;
    tick(); tick();
    checks++; if (err !== 1'b1) $display("FAIL err_set: got %b exp 1", err); else passes++;
    for (int i = 0; i < 4; i++) push(DW'(8'h21 + i));
    for (int c = 0; c < 20 && got.size() < 1; c++) tick();
    for (int c = 0; c < 4; c++) tick();
    checks++; if (err !== 1'b1) $display("FAIL err_sticky: got %b exp 1", err); else passes++;
    checks++; if (got.size() != 1 || got[0] !== word_t'{32'h24232221, 4'hF, 1'b0})
      $display("FAIL err_word: got %0d words first %h exp 24232221", got.size(), got.size() ? got[0].d : '0);
    else passes++;
  endtask

  task automatic test_reset_mid();
    got.delete();
    out_ready = 0;
    for (int i = 0; i < 6; i++) push(DW'(8'h31 + i));
    for (int c = 0; c < 16; c++) tick();
    checks++; if (out_valid !== 1'b1) $display("FAIL rm_pre_valid: got %b exp 1", out_valid); else passes++;
    #2 rst = 1;
    #1;
    checks++; if ({out_valid, out_last, err, fifo_rd_ready} !== 4'b0) $display("FAIL rm_async_flags: got %b exp 0", {out_valid, out_last, err, fifo_rd_ready}); else passes++;
    checks++; if ({out_data, out_be} !== '0) $display("FAIL rm_async_data: got %h exp 0", {out_data, out_be}); else passes++;
    fq.delete();
    fifo_empty = 1; fifo_rd_valid = 0;
    tick(); tick();
    rst = 0;
    out_ready = 1;
    for (int i = 0; i < 4; i++) push(DW'(8'h41 + i));
    for (int c = 0; c < 20 && got.size() < 1; c++) tick();
    checks++; if (got.size() != 1 || got[0] !== word_t'{32'h44434241, 4'hF, 1'b0})
      $display("FAIL rm_clean_word: got %0d words first %h exp 44434241", got.size(), got.size() ? got[0].d : '0);
    else passes++;
  endtask

  // Random streams, random gaps and backpressure; model = chunk entries into PACK, tail flushed.
  task automatic test_random();
    logic [DW-1:0] ent[$];
    word_t exp[$];
    word_t w, held;
    int n, r, idx;
    logic flushed, stall;
    for (int it = 0; it < 4; it++) begin
      ent.delete(); exp.delete(); got.delete();
      n = $urandom_range(5, 15);
      for (int i = 0; i < n; i++) ent.push_back(DW'($urandom));
      for (int b = 0; b < n; b += PK) begin
        w = '0;
        for (int l = 0; l < PK && b + l < n; l++) begin
          w.d[l*DW +: DW] = ent[b+l];
          w.be[l] = 1'b1;
        end
        w.last = (n - b < PK);
        exp.push_back(w);
      end
      r = n % PK;
      idx = 0; flushed = 0;
      for (int c = 0; c < 600 && got.size() < exp.size(); c++) begin
        if (idx < n && $urandom_range(0, 2) != 0) begin push(ent[idx]); idx++; end
        if (idx == n && fifo_empty && r != 0 && !flushed) begin flush = 1; flushed = 1; end
        out_ready = ($urandom_range(0, 3) != 0);
        stall = out_valid && !out_ready;
        held = '{out_data, out_be, out_last};
        tick();
        if (stall) begin
          checks++; if (!out_valid || held !== word_t'{out_data, out_be, out_last})
            $display("FAIL rnd_hold_it%0d: got %b/%h exp 1/%h", it, out_valid, word_t'{out_data, out_be, out_last}, held);
          else passes++;
        end
      end
      out_ready = 1;
      for (int c = 0; c < 6; c++) tick();
      checks++; if (got.size() != exp.size()) $display("FAIL rnd_count_it%0d: got %0d exp %0d", it, got.size(), exp.size()); else passes++;
      for (int k = 0; k < exp.size() && k < got.size(); k++) begin
        checks++; if (got[k] !== exp[k]) $display("FAIL rnd_word_it%0d_%0d: got %h exp %h", it, k, got[k], exp[k]); else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush_partial();
    test_flush_inflight();
    test_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1);
  end
endmodule
